// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: 2-flop synchroniser, debounce, press/release
// edge pulses and per-channel auto-repeat pulse generation.
module button_conditioner #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_RATE   = 5000000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat,
    output logic            btn_any
);

    localparam int unsigned DCNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCNT_W  = $clog2(RPT_MAX + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(STABLE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);
    localparam logic [N_CH-1:0]   PIN_IDLE   = {N_CH{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    logic [N_CH-1:0]   sync1_q, sync2_q;
    logic [N_CH-1:0]   sample_c;
    logic [N_CH-1:0]   level_q, level_d;
    logic [N_CH-1:0]   press_q, press_d;
    logic [N_CH-1:0]   release_q, release_d;
    logic [N_CH-1:0]   repeat_q, repeat_d;
    logic [DCNT_W-1:0] dcnt_q [N_CH];
    logic [DCNT_W-1:0] dcnt_d [N_CH];
    logic [RCNT_W-1:0] rcnt_q [N_CH];
    logic [RCNT_W-1:0] rcnt_d [N_CH];
    rpt_state_e        state_q [N_CH];
    rpt_state_e        state_d [N_CH];

    // Synchronised pin normalised to 1 = pressed
    assign sample_c = sync2_q ^ PIN_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= PIN_IDLE;
            sync2_q   <= PIN_IDLE;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                dcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                dcnt_q[i]  <= dcnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // Debounce: level flips once the sample has disagreed for STABLE_CYCLES edges
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            dcnt_d[i] = '0;
            if (sample_c[i] != level_q[i]) begin
                if (dcnt_q[i] == DCNT_LAST) begin
                    level_d[i]   = sample_c[i];
                    press_d[i]   = sample_c[i];
                    release_d[i] = ~sample_c[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
                end
            end
        end
    end

    // Auto-repeat FSM; rcnt counts cycles since the press or the last repeat pulse.
    // A release being accepted this edge wins over a due repeat pulse.
    always_comb begin
        repeat_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            unique case (state_q[i])
                IDLE: begin
                    rcnt_d[i] = '0;
                    if (press_q[i] && repeat_en[i] && !release_d[i]) begin
                        if (REPEAT_DELAY == 1) begin
                            state_d[i]  = REPEAT;
                            repeat_d[i] = 1'b1;
                        end else begin
                            state_d[i] = HOLD;
                            rcnt_d[i]  = RCNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (release_d[i] || !level_q[i] || !repeat_en[i]) begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end else if (rcnt_q[i] == DELAY_LAST) begin
                        state_d[i]  = REPEAT;
                        repeat_d[i] = 1'b1;
                        rcnt_d[i]   = '0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (release_d[i] || !level_q[i] || !repeat_en[i]) begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end else if (rcnt_q[i] == RATE_LAST) begin
                        repeat_d[i] = 1'b1;
                        rcnt_d[i]   = '0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    rcnt_d[i]  = '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign btn_any     = |level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_in;
    logic [3:0] repeat_en;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
    logic       btn_any;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .N_CH(4), .STABLE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .btn_any(btn_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".level"},   btn_level,        4'b0000);
        check({tag, ".press"},   btn_press,        4'b0000);
        check({tag, ".release"}, btn_release,      4'b0000);
        check({tag, ".repeat"},  btn_repeat,       4'b0000);
        check({tag, ".any"},     {3'b000, btn_any}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rpt;

        // Reset with all pins pressed
        rst_n     = 1'b0;
        btn_in    = 4'b0000;
        repeat_en = 4'b0000;
        cyc(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc(5);
        check("rst_rel.level_e5", btn_level, 4'b0000);
        cyc(1);
        check("rst_rel.level_e6", btn_level, 4'b1111);
        check("rst_rel.press_e6", btn_press, 4'b1111);
        check("rst_rel.any_e6", {3'b000, btn_any}, 4'b0001);
        cyc(1);
        check("rst_rel.press_off", btn_press, 4'b0000);
        btn_in = 4'b1111;
        cyc(5);
        check("all_rel.level_e5", btn_level, 4'b1111);
        cyc(1);
        check("all_rel.level_e6", btn_level, 4'b0000);
        check("all_rel.release_e6", btn_release, 4'b1111);
        check("all_rel.any_e6", {3'b000, btn_any}, 4'b0000);
        check("all_rel.repeat", btn_repeat, 4'b0000);
        cyc(1);
        check("all_rel.release_off", btn_release, 4'b0000);

        // Glitch of 3 cycles on ch0 is rejected
        btn_in = 4'b1110;
        cyc(3);
        btn_in = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            check("glitch.level", btn_level, 4'b0000);
            check("glitch.press", btn_press, 4'b0000);
        end

        // ch1 clean press then release, no repeat enabled
        btn_in = 4'b1101;
        cyc(5);
        check("ch1.level_e5", btn_level, 4'b0000);
        cyc(1);
        check("ch1.level_e6", btn_level, 4'b0010);
        check("ch1.press_e6", btn_press, 4'b0010);
        cyc(1);
        check("ch1.press_off", btn_press, 4'b0000);
        btn_in = 4'b1111;
        cyc(5);
        check("ch1.release_e5", btn_release, 4'b0000);
        cyc(1);
        check("ch1.release_e6", btn_release, 4'b0010);
        check("ch1.level_rel", btn_level, 4'b0000);
        cyc(1);
        check("ch1.release_off", btn_release, 4'b0000);

        // ch2 held 60 cycles with repeat: pulses at P+20,28,36,44,52, none at release P+60
        repeat_en = 4'b0100;
        btn_in    = 4'b1011;
        cyc(6);
        check("ch2.press", btn_press, 4'b0100);
        for (int k = 1; k <= 70; k++) begin
            cyc(1);
            exp_rpt = (k <= 52 && k >= 20 && ((k - 20) % 8) == 0) ? 4'b0100 : 4'b0000;
            check($sformatf("ch2.repeat_p%0d", k), btn_repeat, exp_rpt);
            if (k == 60) check("ch2.release_p60", btn_release, 4'b0100);
            if (k == 54) btn_in = 4'b1111;
        end

        // ch0+ch3 simultaneous press; repeat on ch3 cancelled then re-enabled while held
        repeat_en = 4'b1000;
        btn_in    = 4'b0110;
        cyc(6);
        check("dual.press", btn_press, 4'b1001);
        check("dual.level", btn_level, 4'b1001);
        check("dual.any", {3'b000, btn_any}, 4'b0001);
        for (int k = 1; k <= 40; k++) begin
            if (k == 5)  repeat_en = 4'b0000;
            if (k == 10) repeat_en = 4'b1000;
            cyc(1);
            check($sformatf("dual.no_repeat_p%0d", k), btn_repeat, 4'b0000);
        end
        btn_in = 4'b1111;
        cyc(6);
        check("dual.release", btn_release, 4'b1001);
        check("dual.any_off", {3'b000, btn_any}, 4'b0000);

        // Async reset while ch2 is repeating, pin kept held
        repeat_en = 4'b0100;
        btn_in    = 4'b1011;
        cyc(6);
        check("rst2.press", btn_press, 4'b0100);
        cyc(25);
        check("rst2.level_before", btn_level, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        check("rst2.level_e5", btn_level, 4'b0000);
        cyc(1);
        check("rst2.repress", btn_press, 4'b0100);
        for (int k = 1; k <= 28; k++) begin
            cyc(1);
            exp_rpt = (k == 20 || k == 28) ? 4'b0100 : 4'b0000;
            check($sformatf("rst2.repeat_p%0d", k), btn_repeat, exp_rpt);
        end
        btn_in = 4'b1111;
        cyc(8);
        check("final.level", btn_level, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
